// File: rtl/memctrl_if.sv
// Cache-side refill bus between the instruction cache controller and memctrl.
// The cache holds memory_stb/memory_addr until it sees the one-cycle memory_ack;
// memory_data is valid in the ack cycle and held afterwards.
interface memctrl_if;
    logic        memory_stb;
    logic [13:0] memory_addr;
    logic [31:0] memory_data;
    logic        memory_ack;

    // Cache side: issues requests, consumes the returned word.
    modport master (
        output memory_stb,
        output memory_addr,
        input  memory_data,
        input  memory_ack
    );

    // Controller side: accepts requests, returns the word with an ack pulse.
    modport slave (
        input  memory_stb,
        input  memory_addr,
        output memory_data,
        output memory_ack
    );
endinterface

// File: rtl/memctrl.sv
// memctrl: serves instruction-cache refills. Each request fetches one 32-bit
// word as two big-endian halfwords (even halfword first -> bits [31:16]) from a
// 16-bit external RAM, spending WAIT_CYCLES clocks on each halfword. All
// outputs are registered so they never glitch and never depend combinationally
// on the strobe.
module memctrl #(
    parameter int WAIT_CYCLES = 2    // RAM access time per halfword, 1..15
) (
    input  logic        clk,
    input  logic        rst,
    memctrl_if.slave    bus,
    output logic        ram_oe,
    output logic [14:0] ram_addr,
    input  logic [15:0] ram_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HI   = 2'd1,
        ST_LO   = 2'd2,
        ST_ACK  = 2'd3
    } state_t;

    // Wait-counter reload value: the phase ends when the counter reaches zero,
    // so a phase lasts exactly WAIT_CYCLES cycles.
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t      state_q,       state_d;
    logic [13:0] addr_buf_q,    addr_buf_d;
    logic [3:0]  cnt_q,         cnt_d;
    logic [15:0] data_hi_q,     data_hi_d;
    logic [31:0] memory_data_q, memory_data_d;
    logic        memory_ack_q,  memory_ack_d;
    logic        ram_oe_q,      ram_oe_d;
    logic [14:0] ram_addr_q,    ram_addr_d;

    // Next-state and datapath: address is captured only in IDLE, the high
    // halfword is parked in data_hi, and the full word is committed on LO->ACK.
    always_comb begin
        state_d       = state_q;
        addr_buf_d    = addr_buf_q;
        cnt_d         = cnt_q;
        data_hi_d     = data_hi_q;
        memory_data_d = memory_data_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.memory_stb) begin
                    addr_buf_d = bus.memory_addr;
                    cnt_d      = CNT_INIT;
                    state_d    = ST_HI;
                end
            end
            ST_HI: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    data_hi_d = ram_data;
                    cnt_d     = CNT_INIT;
                    state_d   = ST_LO;
                end
            end
            ST_LO: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    memory_data_d = {data_hi_q, ram_data};
                    state_d       = ST_ACK;
                end
            end
            ST_ACK: begin
                // The strobe is still high here; ignore it so the same
                // request is not served twice.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs line up
    // with the state they belong to, without any combinational path from
    // the strobe to the pins.
    always_comb begin
        ram_oe_d     = (state_d == ST_HI) || (state_d == ST_LO);
        ram_addr_d   = ram_oe_d ? {addr_buf_d, (state_d == ST_LO)} : 15'd0;
        memory_ack_d = (state_d == ST_ACK);
    end

    // State and output registers; reset clears everything immediately so an
    // interrupted transaction drops ram_oe and never acks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            addr_buf_q    <= 14'd0;
            cnt_q         <= 4'd0;
            data_hi_q     <= 16'd0;
            memory_data_q <= 32'd0;
            memory_ack_q  <= 1'b0;
            ram_oe_q      <= 1'b0;
            ram_addr_q    <= 15'd0;
        end else begin
            state_q       <= state_d;
            addr_buf_q    <= addr_buf_d;
            cnt_q         <= cnt_d;
            data_hi_q     <= data_hi_d;
            memory_data_q <= memory_data_d;
            memory_ack_q  <= memory_ack_d;
            ram_oe_q      <= ram_oe_d;
            ram_addr_q    <= ram_addr_d;
        end
    end

    assign bus.memory_data = memory_data_q;
    assign bus.memory_ack  = memory_ack_q;
    assign ram_oe          = ram_oe_q;
    assign ram_addr        = ram_addr_q;

endmodule
